parking_slot_ctrl: RTL

- Multi-slot successor to the single-bay parking FSM. It runs an entry gate with timeouts and allocates the lowest free bay to each admitted car.
- It keeps a per-bay occupancy map and a count, and processes exits independently of entry.
- It sits between the gate and bay sensors and the display and barrier drivers of the parking subsystem.

---
 rtl/parking_pkg.sv | 18 +
 rtl/parking_free_finder.sv | 29 ++
 rtl/parking_slot_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the multi-bay parking controller.
//   - park_state_e : entry-gate FSM states and their status codes
//   - STATUS_W     : width of the status output
//   - DEF_*        : default lot size and gate timeout
package parking_pkg;

   localparam int STATUS_W         = 3;
   localparam int DEF_NUM_SLOTS    = 8;
   localparam int DEF_GATE_TIMEOUT = 16;

   typedef enum logic [STATUS_W-1:0] {
      CLOSE  = 3'd0,
      OPEN   = 3'd1,
      GUIDE  = 3'd2,
      COMMIT = 3'd3
   } park_state_e;

endpackage : parking_pkg

// File: rtl/parking_free_finder.sv
// Combinational priority encoder over the bay occupancy map.
// Ports:
//   slot_map  in   NUM_SLOTS  bit i set means bay i is occupied
//   free_idx  out  SLOT_W     lowest index whose bit is clear (0 if none)
//   any_free  out  1          at least one bay is clear
module parking_free_finder
   import parking_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] slot_map,
   output logic [SLOT_W-1:0]    free_idx,
   output logic                 any_free
);

   // Scan from the top down so the last hit written is the lowest free index.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slot_map[i]) begin
            free_idx = SLOT_W'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule : parking_free_finder

// File: rtl/parking_slot_ctrl.sv
// Multi-bay parking controller: entry gate FSM with timeouts, lowest-free
// bay allocation, per-bay occupancy map and an independent exit path.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   entry_sn        car present at the entry gate (level)
//   car_pass        car has passed the barrier (pulse)
//   park_ack        car has reached its assigned bay (pulse)
//   exit_req        a car is leaving bay exit_slot (pulse)
//   exit_slot       bay being vacated, qualified by exit_req
//   status          FSM state code (doubles as the state debug output)
//   gate_open       barrier open command
//   assign_valid    assigned_slot holds a live reservation
//   assigned_slot   reserved bay index
//   slot_map        occupancy map, bit i = bay i occupied
//   occupancy       number of occupied bays
//   full            occupancy == NUM_SLOTS
//   entry_reject    1-cycle pulse: entry refused, lot full
//   timeout_err     1-cycle pulse: OPEN or GUIDE timed out
//   exit_err        1-cycle pulse: exit for a bay that is not occupied
//
// Handshake semantics: there is no back-pressure anywhere. assign_valid is a
// qualifier only: whenever it is high, assigned_slot names the bay reserved
// for the car currently between gate and bay. The three *_err/_reject outputs
// are single-cycle registered pulses and are not held until acknowledged.
module parking_slot_ctrl
   import parking_pkg::*;
#(
   parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
   parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
   localparam int SLOT_W      = $clog2(NUM_SLOTS),
   localparam int CNT_W       = $clog2(NUM_SLOTS + 1),
   localparam int TMR_W       = $clog2(GATE_TIMEOUT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 entry_sn,
   input  logic                 car_pass,
   input  logic                 park_ack,
   input  logic                 exit_req,
   input  logic [SLOT_W-1:0]    exit_slot,
   output logic [STATUS_W-1:0]  status,
   output logic                 gate_open,
   output logic                 assign_valid,
   output logic [SLOT_W-1:0]    assigned_slot,
   output logic [NUM_SLOTS-1:0] slot_map,
   output logic [CNT_W-1:0]     occupancy,
   output logic                 full,
   output logic                 entry_reject,
   output logic                 timeout_err,
   output logic                 exit_err
);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_SLOTS);

   park_state_e            state_q, state_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic [SLOT_W-1:0]      assigned_slot_q, assigned_slot_d;
   logic [NUM_SLOTS-1:0]   slot_map_q, slot_map_d;
   logic [CNT_W-1:0]       occupancy_q, occupancy_d;
   logic                   entry_sn_q;
   logic                   entry_reject_q, entry_reject_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   exit_err_q, exit_err_d;

   logic [SLOT_W-1:0]      free_idx;
   logic                   any_free;
   logic                   full_w;
   logic                   commit;
   logic                   exit_hit;
   logic [NUM_SLOTS-1:0]   exit_mask;
   logic [NUM_SLOTS-1:0]   commit_mask;

   // Allocation always looks at the registered map, so a bay freed by an
   // exit in the same cycle is not a candidate until the next decision.
   parking_free_finder #(.NUM_SLOTS(NUM_SLOTS)) u_free_finder (
      .slot_map (slot_map_q),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   assign full_w = (occupancy_q == CNT_MAX);

   // -------------------------------------------------------------------------
   // Entry FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= CLOSE;
         timer_q         <= '0;
         assigned_slot_q <= '0;
         entry_sn_q      <= 1'b0;
         entry_reject_q  <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         assigned_slot_q <= assigned_slot_d;
         entry_sn_q      <= entry_sn;
         entry_reject_q  <= entry_reject_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      timer_d         = timer_q;
      assigned_slot_d = assigned_slot_q;
      entry_reject_d  = 1'b0;
      timeout_err_d   = 1'b0;
      commit          = 1'b0;

      case (state_q)
         CLOSE: begin
            timer_d = '0;
            if (entry_sn) begin
               if (!full_w && any_free) begin
                  state_d         = OPEN;
                  assigned_slot_d = free_idx;
               end else if (!entry_sn_q) begin
                  // Reject once per arrival; a car that keeps waiting does
                  // not generate a pulse every cycle.
                  entry_reject_d = 1'b1;
               end
            end
         end

         OPEN: begin
            if (car_pass) begin
               state_d = GUIDE;
               timer_d = '0;
            end else if (timer_q == TMR_LAST) begin
               state_d       = CLOSE;
               timer_d       = '0;
               timeout_err_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         GUIDE: begin
            if (park_ack) begin
               state_d = COMMIT;
               timer_d = '0;
            end else if (timer_q == TMR_LAST) begin
               state_d       = CLOSE;
               timer_d       = '0;
               timeout_err_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         COMMIT: begin
            commit  = 1'b1;
            state_d = CLOSE;
            timer_d = '0;
         end

         default: begin
            state_d = CLOSE;
            timer_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Occupancy map and exit path
   // -------------------------------------------------------------------------
   // One-hot decodes; an exit_slot at or above NUM_SLOTS decodes to all-zero
   // and therefore always lands in the exit_err branch.
   always_comb begin
      exit_mask   = '0;
      commit_mask = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         exit_mask[i]   = (exit_slot == SLOT_W'(i));
         commit_mask[i] = (assigned_slot_q == SLOT_W'(i));
      end
   end

   // The exit is judged against the pre-commit map, so an exit naming the
   // bay being committed this cycle is an error, not a cancel.
   assign exit_hit = exit_req && (|(exit_mask & slot_map_q));

   always_comb begin
      slot_map_d  = slot_map_q;
      occupancy_d = occupancy_q;
      exit_err_d  = exit_req && !exit_hit;

      if (exit_hit) begin
         slot_map_d = slot_map_d & ~exit_mask;
      end
      if (commit) begin
         slot_map_d = slot_map_d | commit_mask;
      end

      case ({commit, exit_hit})
         2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
         2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
         default: occupancy_d = occupancy_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_map_q  <= '0;
         occupancy_q <= '0;
         exit_err_q  <= 1'b0;
      end else begin
         slot_map_q  <= slot_map_d;
         occupancy_q <= occupancy_d;
         exit_err_q  <= exit_err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: registered or decoded from registered state only
   // -------------------------------------------------------------------------
   assign status        = state_q;
   assign gate_open     = (state_q == OPEN);
   assign assign_valid  = (state_q == OPEN) || (state_q == GUIDE) || (state_q == COMMIT);
   assign assigned_slot = assigned_slot_q;
   assign slot_map      = slot_map_q;
   assign occupancy     = occupancy_q;
   assign full          = full_w;
   assign entry_reject  = entry_reject_q;
   assign timeout_err   = timeout_err_q;
   assign exit_err      = exit_err_q;

   // Occupancy must never exceed the lot size.
   a_occ_range : assert property (@(posedge clk) disable iff (!rst_n)
      occupancy_q <= CNT_MAX);

   // A commit must always target a bay that is still free.
   a_commit_free : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == COMMIT) |-> !(|(slot_map_q & commit_mask)));

endmodule : parking_slot_ctrl
